// File: rtl/multi_clock_divider_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : multi_clock_divider_pkg
//  Description : Shared types and default constants for the multi-channel
//                programmable clock divider.
//                - phase_t      : per-channel phase (IDLE / HIGH / LOW)
//                - DEF_NUM_CH   : default number of divider channels
//                - DEF_CNT_W    : default phase-counter / divisor width
//  Revision    : 1.0 - initial release
// ============================================================================
package multi_clock_divider_pkg;

    localparam int DEF_NUM_CH = 4;
    localparam int DEF_CNT_W  = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } phase_t;

endpackage
`default_nettype wire

// File: rtl/divider_channel.sv
`default_nettype none
// ============================================================================
//  Module      : divider_channel
//  Description : One programmable divider channel. Separate high/low phase
//                lengths, one-cycle rise/fall ticks, and shadow divisor
//                registers adopted only at the LOW->HIGH period boundary,
//                at start, or on sync_restart.
//  Ports       : inclk        - system clock
//                Reset        - asynchronous active-high reset
//                en           - channel enable (level)
//                sync_restart - restart strobe (ignored while disabled)
//                cfg_high/low - phase length minus 1, written to shadow
//                cfg_load     - shadow write strobe
//                cfg_pending  - shadow written, not yet adopted
//                outclk       - divided clock (registered)
//                rise_tick    - first cycle outclk reads 1
//                fall_tick    - first cycle outclk reads 0
//  Revision    : 1.0 - initial release
// ============================================================================
module divider_channel
    import multi_clock_divider_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             inclk,
    input  logic             Reset,
    input  logic             en,
    input  logic             sync_restart,
    input  logic [CNT_W-1:0] cfg_high,
    input  logic [CNT_W-1:0] cfg_low,
    input  logic             cfg_load,
    output logic             cfg_pending,
    output logic             outclk,
    output logic             rise_tick,
    output logic             fall_tick
);

    localparam logic [CNT_W-1:0] c_one = {{(CNT_W-1){1'b0}}, 1'b1};

    phase_t           r_state;
    logic             r_en_q;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_shadow_high;
    logic [CNT_W-1:0] r_shadow_low;
    logic [CNT_W-1:0] r_active_high;
    logic [CNT_W-1:0] r_active_low;

    always_ff @(posedge inclk or posedge Reset) begin
        if (Reset) begin
            r_state       <= IDLE;
            r_en_q        <= 1'b0;
            r_count       <= '0;
            r_shadow_high <= '0;
            r_shadow_low  <= '0;
            r_active_high <= '0;
            r_active_low  <= '0;
            cfg_pending   <= 1'b0;
            outclk        <= 1'b0;
            rise_tick     <= 1'b0;
            fall_tick     <= 1'b0;
        end else begin
            rise_tick <= 1'b0;
            fall_tick <= 1'b0;
            r_en_q    <= en;

            if (!en) begin
                r_state   <= IDLE;
                r_count   <= '0;
                outclk    <= 1'b0;
                fall_tick <= outclk;
            end else if (!r_en_q || sync_restart) begin
                // Start and restart share one path; a restart while already
                // high only suppresses the rise tick.
                r_active_high <= r_shadow_high;
                r_active_low  <= r_shadow_low;
                cfg_pending   <= 1'b0;
                r_count       <= '0;
                r_state       <= HIGH;
                outclk        <= 1'b1;
                rise_tick     <= ~outclk;
            end else begin
                case (r_state)
                    HIGH: begin
                        if (r_count == r_active_high) begin
                            r_count   <= '0;
                            r_state   <= LOW;
                            outclk    <= 1'b0;
                            fall_tick <= 1'b1;
                        end else begin
                            r_count <= r_count + c_one;
                        end
                    end
                    LOW: begin
                        if (r_count == r_active_low) begin
                            // Period boundary: the only place divisors change
                            // while running, so the output never glitches.
                            r_active_high <= r_shadow_high;
                            r_active_low  <= r_shadow_low;
                            cfg_pending   <= 1'b0;
                            r_count       <= '0;
                            r_state       <= HIGH;
                            outclk        <= 1'b1;
                            rise_tick     <= 1'b1;
                        end else begin
                            r_count <= r_count + c_one;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end

            // Placed last so a write on an adoption edge overrides the clear:
            // the adoption above used the previous shadow contents.
            if (cfg_load) begin
                r_shadow_high <= cfg_high;
                r_shadow_low  <= cfg_low;
                cfg_pending   <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/multi_clock_divider.sv
`default_nettype none
// ============================================================================
//  Module      : multi_clock_divider
//  Description : NUM_CH independent programmable clock dividers sharing one
//                configuration write bus and a global sync_restart.
//  Ports       : inclk        - system clock (CLK_50M)
//                Reset        - asynchronous active-high reset
//                en           - per-channel enable
//                sync_restart - phase-align all enabled channels
//                cfg_high/low - shared phase-length-minus-1 write bus
//                cfg_load     - per-channel shadow write strobe
//                cfg_pending  - per-channel shadow-not-yet-adopted flag
//                outclk       - divided clocks
//                outclk_Not   - inverse of outclk
//                rise_tick    - per-channel rise strobes
//                fall_tick    - per-channel fall strobes
//  Revision    : 1.0 - initial release
// ============================================================================
module multi_clock_divider
    import multi_clock_divider_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              inclk,
    input  logic              Reset,
    input  logic [NUM_CH-1:0] en,
    input  logic              sync_restart,
    input  logic [CNT_W-1:0]  cfg_high,
    input  logic [CNT_W-1:0]  cfg_low,
    input  logic [NUM_CH-1:0] cfg_load,
    output logic [NUM_CH-1:0] cfg_pending,
    output logic [NUM_CH-1:0] outclk,
    output logic [NUM_CH-1:0] outclk_Not,
    output logic [NUM_CH-1:0] rise_tick,
    output logic [NUM_CH-1:0] fall_tick
);

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            divider_channel #(
                .CNT_W(CNT_W)
            ) u_channel (
                .inclk       (inclk),
                .Reset       (Reset),
                .en          (en[i]),
                .sync_restart(sync_restart),
                .cfg_high    (cfg_high),
                .cfg_low     (cfg_low),
                .cfg_load    (cfg_load[i]),
                .cfg_pending (cfg_pending[i]),
                .outclk      (outclk[i]),
                .rise_tick   (rise_tick[i]),
                .fall_tick   (fall_tick[i])
            );
        end
    endgenerate

    assign outclk_Not = ~outclk;

endmodule
`default_nettype wire
